seq_bit_serializer: RTL and testbench

SEQ_BIT_SERIALIZER -- requirements
Module: seq_bit_serializer

---
 rtl/seq_pkg.sv | 15 +
 rtl/seq_bit_serializer.sv | 110 +++++++++++
 tb/tb_seq_bit_serializer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and defaults for the serializer / sequence detector pair.
// Holds the FSM state encoding and the default word width and gap length.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } seq_state_t;

  localparam int SEQ_WIDTH   = 8;
  localparam int SEQ_GAP     = 0;
  localparam int SEQ_GAP_MAX = 15;

endpackage

// File: rtl/seq_bit_serializer.sv
// Word-to-bit serializer with a hold register in front of the shifter.
// Ports: clk, reset (async, active-high); in_data/in_valid/in_ready
// word input; flush (sync abort); seq/valid serial out; busy status.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int WIDTH      = SEQ_WIDTH,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = SEQ_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  output logic             seq,
  output logic             valid,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam int GL = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0] GLAST = 4'(GL);

  seq_state_t       state;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt;
  logic [3:0]       gcnt;
  logic             accept;
  logic             load;
  logic             last_bit;
  logic             gap_done;
  logic             out_bit;

  assign in_ready = !hold_full && !flush;
  assign accept   = in_valid && in_ready;
  assign last_bit = (state == ST_SHIFT) && (cnt == LAST);
  assign gap_done = (state == ST_GAP) && (gcnt == 4'd0);

  // Refill the shifter whenever the current word (and its gap) is done.
  assign load = hold_full &&
                ((state == ST_IDLE) ||
                 (last_bit && (GAP_CYCLES == 0)) ||
                 gap_done);

  assign shifted = (MSB_FIRST != 0) ?
                   {shreg[WIDTH-2:0], 1'b0} :
                   {1'b0, shreg[WIDTH-1:1]};
  assign out_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

  assign valid = (state == ST_SHIFT);
  assign seq   = valid && out_bit;
  assign busy  = hold_full || (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold_q    <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      gcnt      <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      hold_q    <= '0;
      hold_full <= 1'b0;
      shreg     <= '0;
      cnt       <= '0;
      gcnt      <= '0;
    end else begin
      // accept needs an empty hold, load a full one: never both
      if (accept) begin
        hold_q    <= in_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load) begin
        shreg <= hold_q;
        cnt   <= '0;
        state <= ST_SHIFT;
      end else begin
        unique case (1'b1)
          (state == ST_SHIFT): begin
            shreg <= shifted;
            if (!last_bit) begin
              cnt <= cnt + 1'b1;
            end else if (GAP_CYCLES > 0) begin
              state <= ST_GAP;
              gcnt  <= GLAST;
            end else begin
              state <= ST_IDLE;
            end
          end
          (state == ST_GAP): begin
            if (gap_done) state <= ST_IDLE;
            else gcnt <= gcnt - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench for seq_bit_serializer: two instances
// (MSB-first no gap, LSB-first gap 3) against a queue-based model.
module tb_seq_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] id  [2];
  logic       iv  [2];
  logic       fl  [2];
  logic       rdy [2];
  logic       sq  [2];
  logic       vld [2];
  logic       bsy [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)
  ) dut0 (
    .clk(clk), .reset(reset), .in_data(id[0]),
    .in_valid(iv[0]), .in_ready(rdy[0]), .flush(fl[0]),
    .seq(sq[0]), .valid(vld[0]), .busy(bsy[0])
  );

  seq_bit_serializer #(
    .WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(3)
  ) dut1 (
    .clk(clk), .reset(reset), .in_data(id[1]),
    .in_valid(iv[1]), .in_ready(rdy[1]), .flush(fl[1]),
    .seq(sq[1]), .valid(vld[1]), .busy(bsy[1])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // Model: one slot for the held word, plus a queue of output
  // symbols {valid,seq} still to appear for the word in flight.
  logic [1:0] mq [2][$];
  logic [7:0] mh [2];
  bit         mfull [2];

  always @(posedge clk or posedge reset) begin
    logic acc;
    logic b;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        mq[k].delete();
        mfull[k] = 1'b0;
      end else if (fl[k]) begin
        mq[k].delete();
        mfull[k] = 1'b0;
      end else begin
        acc = iv[k] && !mfull[k];
        if (mq[k].size() > 0) void'(mq[k].pop_front());
        if (mq[k].size() == 0 && mfull[k]) begin
          for (int i = 0; i < 8; i++) begin
            b = (k == 0) ? mh[k][7-i] : mh[k][i];
            mq[k].push_back({1'b1, b});
          end
          for (int g = 0; g < ((k == 0) ? 0 : 3); g++)
            mq[k].push_back(2'b00);
          mfull[k] = 1'b0;
        end
        if (acc) begin
          mh[k]    = id[k];
          mfull[k] = 1'b1;
        end
      end
    end
  end

  logic [31:0] cap  [2];
  int          ncap [2];
  int          run0;
  int          maxrun0;

  always @(negedge clk) begin
    logic [1:0] e;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        e = (mq[k].size() > 0) ? mq[k][0] : 2'b00;
        chk($sformatf("valid%0d", k), 32'(vld[k]), 32'(e[1]));
        chk($sformatf("seq%0d", k), 32'(sq[k]), 32'(e[0]));
        chk($sformatf("busy%0d", k), 32'(bsy[k]),
            32'(mfull[k] || mq[k].size() > 0));
        chk($sformatf("ready%0d", k), 32'(rdy[k]),
            32'(!mfull[k] && !fl[k]));
        if (vld[k]) begin
          cap[k] = {cap[k][30:0], sq[k]};
          ncap[k]++;
        end
      end
      run0 = vld[0] ? run0 + 1 : 0;
      if (run0 > maxrun0) maxrun0 = run0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] w);
    int  n;
    logic r;
    id[k] = w;
    iv[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      r = rdy[k];
      tick();
      n++;
    end while (!r && n < 100);
    chk($sformatf("accept%0d", k), 32'(r), 32'd1);
    iv[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (bsy[k] && n < 200) begin
      tick();
      n++;
    end
    chk($sformatf("idle%0d", k), 32'(bsy[k]), 32'd0);
  endtask

  task automatic clr_cap();
    for (int k = 0; k < 2; k++) begin
      cap[k]  = '0;
      ncap[k] = 0;
    end
    run0    = 0;
    maxrun0 = 0;
  endtask

  typedef struct {
    int         k;
    logic [7:0] w;
    logic [7:0] e;
  } vec_t;

  vec_t tv [6];

  initial begin
    int n;
    tv[0] = '{0, 8'hB6, 8'b10110110};
    tv[1] = '{0, 8'hA5, 8'b10100101};
    tv[2] = '{0, 8'h01, 8'b00000001};
    tv[3] = '{1, 8'h01, 8'b10000000};
    tv[4] = '{1, 8'hB6, 8'b01101101};
    tv[5] = '{1, 8'h80, 8'b00000001};

    for (int k = 0; k < 2; k++) begin
      id[k] = '0;
      iv[k] = 1'b0;
      fl[k] = 1'b0;
    end
    clr_cap();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_valid%0d", k), 32'(vld[k]), 32'd0);
      chk($sformatf("rst_seq%0d", k), 32'(sq[k]), 32'd0);
      chk($sformatf("rst_busy%0d", k), 32'(bsy[k]), 32'd0);
      chk($sformatf("rst_ready%0d", k), 32'(rdy[k]), 32'd1);
    end
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      clr_cap();
      send(tv[i].k, tv[i].w);
      wait_idle(tv[i].k);
      chk($sformatf("vec%0d_bits", i), cap[tv[i].k][7:0], tv[i].e);
      chk($sformatf("vec%0d_n", i), ncap[tv[i].k], 8);
    end

    clr_cap();
    send(0, 8'hA5);
    send(0, 8'h3C);
    wait_idle(0);
    chk("b2b_run", maxrun0, 16);
    chk("b2b_bits", cap[0][15:0], 16'hA53C);

    clr_cap();
    send(0, 8'hFF);
    send(0, 8'h0F);
    n = 0;
    while (ncap[0] < 3 && n < 100) begin
      tick();
      n++;
    end
    chk("flush_reach", 32'(ncap[0] >= 3), 32'd1);
    fl[0] = 1'b1;
    tick();
    fl[0] = 1'b0;
    chk("flush_valid", 32'(vld[0]), 32'd0);
    chk("flush_busy", 32'(bsy[0]), 32'd0);
    repeat (20) tick();
    chk("flush_n", ncap[0], 4);
    chk("flush_bits", cap[0][3:0], 4'hF);

    clr_cap();
    send(0, 8'hFF);
    n = 0;
    while (ncap[0] < 3 && n < 100) begin
      tick();
      n++;
    end
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 32'(vld[0]), 32'd0);
    chk("arst_busy", 32'(bsy[0]), 32'd0);
    chk("arst_ready", 32'(rdy[0]), 32'd1);
    tick();
    reset = 1'b0;
    tick();
    clr_cap();
    send(0, 8'h80);
    wait_idle(0);
    chk("arst_bits", cap[0][7:0], 8'h80);
    chk("arst_n", ncap[0], 8);

    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 2; k++) begin
        iv[k] = 1'($urandom_range(0, 1));
        id[k] = 8'($urandom);
        fl[k] = ($urandom_range(0, 24) == 0);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0;
      fl[k] = 1'b0;
    end
    wait_idle(0);
    wait_idle(1);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks,
             errors);
    $finish;
  end

endmodule
